code_seq_checker: RTL
=====================

Name: code_seq_checker

Overview:
Downstream consumer of the 3-bit code-stream generator. Samples each valid 3-bit code, tracks a programmable cyclic expected sequence, and acquires and loses lock with hysteresis. Counts sequence errors while locked. Its lock/error status is the health indicator for the code stream.

Parameters:
SEQ_LEN, 2, number of symbols in the expected cycle (1..4)
SEQ0, 3'b111, expected symbol at index 0 (also the hunt/sync symbol)
SEQ1, 3'b000, expected symbol at index 1
SEQ2, 3'b000, expected symbol at index 2 (ignored if SEQ_LEN<3)
SEQ3, 3'b000, expected symbol at index 3 (ignored if SEQ_LEN<4)
LOCK_CNT, 4, consecutive matches required to declare lock (>=1)
UNLOCK_CNT, 3, consecutive mismatches while locked that drop lock (>=1)
ERR_W, 8, error counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
code_valid  input  1  code is a new symbol this cycle
code  input  3  symbol from the upstream generator
clear  input  1  synchronous clear of err_cnt
locked  output  1  sequence lock indicator
err_pulse  output  1  one-cycle pulse per mismatch while locked
err_cnt  output  ERR_W  saturating count of mismatches while locked
seq_idx  output  2  index of the next expected symbol

Behaviour:
- Reset (rst_n=0, async): state=HUNT, locked=0, err_pulse=0, err_cnt=0, seq_idx=0, run/miss counters=0.
- Sampling on rising clk. Upstream updates on falling edge, giving half-cycle setup. Cycles with code_valid=0 change nothing, except err_pulse returns to 0 and clear is applied.
- All outputs are registered. Effects are visible the cycle after the sampled symbol.
- Index advance: idx_next = (idx==SEQ_LEN-1) ? 0 : idx+1. With SEQ_LEN=1, idx stays 0.
- HUNT:
  - Valid code==SEQ0 -> SYNC, idx=adv(0), run=1.
  - If LOCK_CNT==1, go directly to LOCKED instead.
  - Any other code: stay in HUNT, idx=0.
- SYNC:
  - Valid code==SEQ[idx] -> run+1, idx advances. When run+1==LOCK_CNT -> LOCKED, locked=1, miss=0.
  - Mismatch where code==SEQ0 -> restart SYNC with idx=adv(0), run=1.
  - Any other mismatch -> HUNT, idx=0, run=0.
  - No err_pulse and no err_cnt change in SYNC.
- LOCKED:
  - Valid match -> miss=0, idx advances.
  - Valid mismatch (flywheel):
    - idx still advances.
    - err_pulse=1 for one cycle.
    - err_cnt increments, saturating at 2^ERR_W-1.
    - miss+1. When miss+1==UNLOCK_CNT -> HUNT, locked=0, idx=0, run=0. err_pulse and the increment still occur for that final mismatch.
- clear: err_cnt=0 next cycle. If clear coincides with an increment, clear wins (err_cnt=0) while err_pulse still fires. clear does not affect state, locked, or seq_idx.
- Counters run/miss are $clog2(max(LOCK_CNT,UNLOCK_CNT)+1) bits and never wrap.
- Mid-operation reset returns immediately to the reset values above. There is no partial-lock memory.

Decomposition:
- Package code_seq_pkg holds:
  - CODE_W=3
  - state enum {HUNT, SYNC, LOCKED} (2 bits)
  - function seq_adv(idx, len) for index wrap
- Sub-module sat_counter (WIDTH param; inc, clr inputs with clr priority; async active-low reset; value output) instantiated for err_cnt.
- FSM, index, and run/miss counters stay in code_seq_checker.

Test Plan:
- Lock acquire (defaults): valid stream 111,000,111,000 -> locked=1 the cycle after the 4th symbol; seq_idx=0; err_cnt=0.
- False start: 111,010,111,000,111,000 -> the 010 returns to HUNT. The next 111 restarts SYNC; locked=1 after the last 000.
- Flywheel error: locked, then feed 111,011,111 (011 replaces 000) -> one err_pulse, err_cnt=1, locked stays 1, seq_idx keeps cycling 1,0,1.
- Lock loss: locked, then three consecutive mismatches 010,010,010 -> three err_pulses, err_cnt=3, locked=0 the cycle after the third; state HUNT, seq_idx=0.
- Saturation/clear (ERR_W=2): 5 isolated mismatches while locked -> err_cnt sticks at 3. Assert clear in the same cycle as a mismatch -> err_cnt=0 and err_pulse=1.
- Async reset mid-lock: drop rst_n between clock edges while locked with err_cnt=2 -> locked=0, err_cnt=0, seq_idx=0 immediately, without waiting for a clock edge. code_valid=0 gaps during a lock change nothing.

Source files
------------

// File: rtl/code_seq_pkg.sv
// Shared definitions for the code-sequence checker.
//   CODE_W  : width of one symbol from the upstream code generator
//   state_e : checker FSM states
//   seq_adv : wrap-around advance of the expected-symbol index
package code_seq_pkg;

    localparam int unsigned CODE_W = 3;

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StSync   = 2'd1,
        StLocked = 2'd2
    } state_e;

    // Next index in a cycle of 'len' symbols (len in 1..4).
    function automatic logic [1:0] seq_adv(input logic [1:0] idx, input int unsigned len);
        if ({30'd0, idx} >= len - 1) begin
            return 2'd0;
        end
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst_n : asynchronous active-low reset (value -> 0)
//   inc   : increment by one, holding at all-ones
//   clr   : synchronous clear, takes priority over inc
//   value : current count
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != {WIDTH{1'b1}})) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/code_seq_checker.sv
// Lock/health checker for a cyclic 3-bit code stream.
// Hunts for SEQ0, confirms LOCK_CNT consecutive in-sequence symbols, then
// flywheels through mismatches, dropping lock after UNLOCK_CNT in a row.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   code_valid : code carries a new symbol this cycle
//   code       : symbol from the upstream generator
//   clear      : synchronous clear of err_cnt
//   locked     : sequence lock indicator
//   err_pulse  : one-cycle pulse per mismatch while locked
//   err_cnt    : saturating mismatch count while locked
//   seq_idx    : index of the next expected symbol
module code_seq_checker
    import code_seq_pkg::*;
#(
    parameter int unsigned       SEQ_LEN    = 2,
    parameter logic [CODE_W-1:0] SEQ0       = 3'b111,
    parameter logic [CODE_W-1:0] SEQ1       = 3'b000,
    parameter logic [CODE_W-1:0] SEQ2       = 3'b000,
    parameter logic [CODE_W-1:0] SEQ3       = 3'b000,
    parameter int unsigned       LOCK_CNT   = 4,
    parameter int unsigned       UNLOCK_CNT = 3,
    parameter int unsigned       ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [1:0]        seq_idx
);

    localparam int unsigned CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_CNT);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  miss_q, miss_d;
    logic              err_pulse_q, err_pulse_d;
    logic              err_inc;
    logic [CODE_W-1:0] exp_sym;
    logic [1:0]        idx_adv, idx_first;
    logic [CNT_W-1:0]  run_inc, miss_inc;

    always_comb begin
        case (idx_q)
            2'd0:    exp_sym = SEQ0;
            2'd1:    exp_sym = SEQ1;
            2'd2:    exp_sym = SEQ2;
            default: exp_sym = SEQ3;
        endcase
    end

    assign idx_adv   = seq_adv(idx_q, SEQ_LEN);
    // Index following a freshly seen sync symbol.
    assign idx_first = seq_adv(2'd0, SEQ_LEN);
    assign run_inc   = run_q + CNT_W'(1);
    assign miss_inc  = miss_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        run_d       = run_q;
        miss_d      = miss_q;
        err_inc     = 1'b0;
        err_pulse_d = 1'b0;

        if (code_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (code == SEQ0) begin
                        idx_d   = idx_first;
                        run_d   = CNT_W'(1);
                        miss_d  = '0;
                        state_d = (LOCK_CNT == 1) ? StLocked : StSync;
                    end else begin
                        idx_d = 2'd0;
                    end
                end
                StSync: begin
                    if (code == exp_sym) begin
                        run_d = run_inc;
                        idx_d = idx_adv;
                        if (run_inc == LOCK_C) begin
                            state_d = StLocked;
                            miss_d  = '0;
                        end
                    end else if (code == SEQ0) begin
                        // Treat an out-of-place sync symbol as a new start.
                        idx_d = idx_first;
                        run_d = CNT_W'(1);
                    end else begin
                        state_d = StHunt;
                        idx_d   = 2'd0;
                        run_d   = '0;
                    end
                end
                StLocked: begin
                    // Flywheel: the index keeps cycling even on a mismatch.
                    idx_d = idx_adv;
                    if (code == exp_sym) begin
                        miss_d = '0;
                    end else begin
                        err_inc     = 1'b1;
                        err_pulse_d = 1'b1;
                        miss_d      = miss_inc;
                        if (miss_inc == UNLOCK_C) begin
                            state_d = StHunt;
                            idx_d   = 2'd0;
                            run_d   = '0;
                            miss_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = StHunt;
                    idx_d   = 2'd0;
                    run_d   = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            idx_q       <= 2'd0;
            run_q       <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_inc),
        .clr  (clear),
        .value(err_cnt)
    );

    assign locked    = (state_q == StLocked);
    assign err_pulse = err_pulse_q;
    assign seq_idx   = idx_q;

endmodule
